// File: rtl/wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// wr_ptr_ctrl
// Write-side pointer and status controller of the synchronous AXI-stream
// FIFO. It owns the (ALEN+1)-bit write pointer, whose top bit is the wrap bit
// that tells full apart from empty. It gates RAM writes, and it produces
// registered full, almost-full and fill count from its own next pointer and
// the read pointer. The read pointer comes from the read-side controller in
// the same clock domain. A write attempted while full is latched in a sticky
// overflow flag.
//
// Status timing: the flags are computed from the *next* write pointer, so a
// write raises them with no lag. i_rptr is the read pointer as it stands
// before the current edge, so a read lowers them one cycle late. That lag only
// ever over-reports fill, which means an entry can never be overwritten.
// ---------------------------------------------------------------------------
module wr_ptr_ctrl #(
  parameter int ALEN         = 8,
  parameter int INCR         = 1,
  parameter int AFULL_THRESH = (2 ** ALEN) - 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_wen,
  input  logic            i_ovf_clr,
  input  logic [ALEN:0]   i_rptr,
  output logic [ALEN-1:0] o_waddr,
  output logic [ALEN:0]   o_wptr,
  output logic            o_ram_wen,
  output logic            o_wfull,
  output logic            o_walmost_full,
  output logic [ALEN:0]   o_wcount,
  output logic            o_woverflow
);

  // Pointer width including the wrap bit. All pointer arithmetic is done at
  // this width, so it wraps naturally modulo 2**(ALEN+1).
  localparam int PW    = ALEN + 1;
  localparam int DEPTH = 2 ** ALEN;

  // Pointer step for each accepted write.
  localparam logic [ALEN:0] LP_INCR = PW'(INCR);

  // Full means "there is no room for one more INCR-sized step": fill > DEPTH-INCR.
  localparam logic [ALEN:0] LP_FULL_LIM = PW'(DEPTH - INCR);

  // Almost-full threshold. It can be as large as DEPTH, which still fits in PW bits.
  localparam logic [ALEN:0] LP_AFULL = PW'(AFULL_THRESH);

  // Registered state.
  logic [ALEN:0] r_wptr;
  logic [ALEN:0] r_wcount;
  logic          r_wfull;
  logic          r_walmost_full;
  logic          r_woverflow;

  // Next-state and combinational terms.
  logic          w_ram_wen;
  logic [ALEN:0] w_wptr_d;
  logic [ALEN:0] w_fill_d;
  logic          w_wfull_d;
  logic          w_walmost_full_d;
  logic          w_ovf_set;
  logic          w_woverflow_d;

  // Fill level between the next write pointer and the read pointer. The
  // subtraction is modulo 2**PW, so it stays correct when either pointer
  // wraps past all-ones back to zero.
  function automatic logic [ALEN:0] f_fill(input logic [ALEN:0] wptr,
                                           input logic [ALEN:0] rptr);
    f_fill = wptr - rptr;
  endfunction

  // Write gating and next pointer. The RAM write lands in the same cycle as
  // the request.
  always_comb begin
    w_ram_wen = 1'b0;
    w_wptr_d  = r_wptr;
    w_ram_wen = i_wen & ~r_wfull;
    if (w_ram_wen) begin
      w_wptr_d = r_wptr + LP_INCR;
    end else begin
      w_wptr_d = r_wptr;
    end
  end

  // Status terms, derived from the post-write pointer and the pre-read read pointer.
  always_comb begin
    w_fill_d         = '0;
    w_wfull_d        = 1'b0;
    w_walmost_full_d = 1'b0;
    w_fill_d         = f_fill(w_wptr_d, i_rptr);
    w_wfull_d        = (w_fill_d > LP_FULL_LIM);
    w_walmost_full_d = (w_fill_d >= LP_AFULL);
  end

  // Sticky overflow. A write attempt while full sets the flag. If a set and
  // a clear arrive in the same cycle, the set wins, so that no event is lost.
  always_comb begin
    w_ovf_set     = 1'b0;
    w_woverflow_d = r_woverflow;
    w_ovf_set     = i_wen & r_wfull;
    if (w_ovf_set) begin
      w_woverflow_d = 1'b1;
    end else if (i_ovf_clr) begin
      w_woverflow_d = 1'b0;
    end else begin
      w_woverflow_d = r_woverflow;
    end
  end

  // State registers. The synchronous reset overrides every input, including a write mid-burst.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr         <= '0;
      r_wcount       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wptr         <= w_wptr_d;
      r_wcount       <= w_fill_d;
      r_wfull        <= w_wfull_d;
      r_walmost_full <= w_walmost_full_d;
      r_woverflow    <= w_woverflow_d;
    end
  end

  assign o_wptr         = r_wptr;
  assign o_waddr        = r_wptr[ALEN-1:0];
  assign o_ram_wen      = w_ram_wen;
  assign o_wfull        = r_wfull;
  assign o_walmost_full = r_walmost_full;
  assign o_wcount       = r_wcount;
  assign o_woverflow    = r_woverflow;

endmodule
